// File: rtl/mem_sram_axi_pkg.sv
// mem_sram_axi_pkg: size encodings, master FSM states and byte-lane helpers
package mem_sram_axi_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WRESP,
        ST_RREQ,
        ST_RDATA,
        ST_DONE
    } state_t;

    // Byte offset of the lowest selected lane; size 11 behaves as a word
    function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
        return sz == SZ_BYTE ? a : sz == SZ_HALF ? {a[1], 1'b0} : 2'b00;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        return sz == SZ_BYTE ? 4'b0001 << a : sz == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] a);
        return d << {lane_off(sz, a), 3'b000};
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] s;
        s = w >> {lane_off(sz, a), 3'b000};
        return sz == SZ_BYTE ? {24'b0, s[7:0]} : sz == SZ_HALF ? {16'b0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/mem_sram_axi_mem.sv
// mem_sram_axi_mem: on-chip SRAM slave on the AXI-Lite-style link
// MEM_SRAM_AXI_ZERO_INIT_EN: when defined, SRAM contents start at zero
module mem_sram_axi_mem
    import mem_sram_axi_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [1:0]        awsize,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [1:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic              rready
);
    localparam int IW = $clog2(MEM_WORDS);

`ifdef MEM_SRAM_AXI_ZERO_INIT_EN
    logic [31:0] mem [MEM_WORDS] = '{default: '0};
`else
    logic [31:0] mem [MEM_WORDS];
`endif

    logic [IW-1:0] widx, ridx;
    logic [3:0]    mask;
    logic          rd_hs;
    logic          unused;

    assign awready = awvalid & wvalid & ~bvalid;
    assign wready  = awready;
    assign arready = ~rvalid;
    assign rd_hs   = arvalid & arready;
    assign widx    = awaddr[IW+1:2];
    assign ridx    = araddr[IW+1:2];
    assign mask    = lane_mask(awsize, awaddr[1:0]);
    assign unused  = ^{awaddr[ADDR_W-1:IW+2], araddr[ADDR_W-1:IW+2], araddr[1:0], arsize};

    // reset on the handshake edge wins so an aborted write never lands
    always_ff @(posedge clk) begin
        if (!rst && awready)
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            bvalid <= awready | (bvalid & ~bready);
            rvalid <= rd_hs | (rvalid & ~rready);
            rdata  <= rd_hs ? mem[ridx] : rdata;
        end
    end
endmodule

// File: rtl/mem_sram_axi_req.sv
// mem_sram_axi_req: request-level master FSM driving the AXI-Lite-style link
module mem_sram_axi_req
    import mem_sram_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              done,
    output logic [ADDR_W-1:0] awaddr,
    output logic [1:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [1:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready
);
    state_t            state;
    logic [ADDR_W-1:0] a_q;
    logic [1:0]        sz_q;
    logic [31:0]       d_q;

    assign awaddr = a_q;
    assign araddr = a_q;
    assign awsize = sz_q;
    assign arsize = sz_q;
    assign wdata  = d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            sz_q    <= '0;
            d_q     <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (en) begin
                    a_q  <= addr;
                    sz_q <= size;
                    // write data leaves the master already placed on its byte lanes
                    d_q  <= align(din, size, addr[1:0]);
                    state   <= wen ? ST_WREQ : ST_RREQ;
                    awvalid <= wen;
                    wvalid  <= wen;
                    arvalid <= ~wen;
                end
                ST_WREQ: begin
                    awvalid <= awvalid & ~awready;
                    wvalid  <= wvalid & ~wready;
                    if ((~awvalid | awready) & (~wvalid | wready)) begin
                        state  <= ST_WRESP;
                        bready <= 1'b1;
                    end
                end
                ST_WRESP: if (bvalid) begin
                    bready <= 1'b0;
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_RREQ: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    state   <= ST_RDATA;
                end
                ST_RDATA: if (rvalid) begin
                    rready <= 1'b0;
                    dout   <= extract(rdata, sz_q, a_q[1:0]);
                    done   <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mem_sram_axi_top.sv
// mem_sram_axi_top: request front end wired to the SRAM slave over an internal AXI-Lite-style link
// MEM_SRAM_AXI_ZERO_INIT_EN: when defined, SRAM contents start at zero
module mem_sram_axi_top
    import mem_sram_axi_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              done
);
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [1:0]        awsize, arsize;
    logic [31:0]       wdata, rdata;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;

    mem_sram_axi_req #(.ADDR_W(ADDR_W)) u_req (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .size(size),
        .din(din), .dout(dout), .done(done),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    mem_sram_axi_mem #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );
endmodule

// File: tb/tb_mem_sram_axi_top.sv
// tb_mem_sram_axi_top: directed-vector bench for mem_sram_axi_top
module tb_mem_sram_axi_top;
    logic        clk = 1'b0;
    logic        rst, en, wen, done;
    logic [31:0] addr, din, dout;
    logic [1:0]  size;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_sram_axi_top #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr),
        .size(size), .din(din), .dout(dout), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 20);
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d);
        int n;
        en = 1'b1; wen = w; addr = a; size = sz; din = d;
        wait_done(n);
        en = 1'b0;
        chk({tag, "_lat"}, n, 3);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'b0, done}, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] exp);
        txn(tag, 1'b0, a, sz, 32'h0);
        chk(tag, dout, exp);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; en = 1'b0; wen = 1'b0; addr = '0; size = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dout", dout, 0);
        chk("rst_done", {31'b0, done}, 0);

        txn("wr_word", 1'b1, 32'h0, 2'b10, 32'hF00FCCAA);
        rd("rd_word0", 32'h0, 2'b10, 32'hF00FCCAA);
`ifdef MEM_SRAM_AXI_ZERO_INIT_EN
        rd("rd_unwritten", 32'h8, 2'b10, 32'h0);
`endif
        txn("wr_byte", 1'b1, 32'h1, 2'b00, 32'h00000055);
        rd("rd_after_byte", 32'h0, 2'b10, 32'hF00F55AA);
        txn("wr_half", 1'b1, 32'h2, 2'b01, 32'h00001234);
        rd("rd_after_half", 32'h0, 2'b10, 32'h123455AA);
        rd("rd_byte3", 32'h3, 2'b00, 32'h00000012);
        rd("rd_half0", 32'h0, 2'b01, 32'h000055AA);
        rd("rd_half1_a0ign", 32'h1, 2'b01, 32'h000055AA);
        rd("rd_size11", 32'h3, 2'b11, 32'h123455AA);

        txn("wr_wrap", 1'b1, 32'd4096, 2'b10, 32'hDEADBEEF);
        chk("dout_hold_on_write", dout, 32'h123455AA);
        rd("rd_wrap", 32'h0, 2'b10, 32'hDEADBEEF);

        txn("wr_c", 1'b1, 32'hC, 2'b10, 32'hAAAA0000);
        en = 1'b1; wen = 1'b1; addr = 32'hC; size = 2'b10; din = 32'h55555555;
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_dout", dout, 0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        chk("abort_nodone", {31'b0, seen}, 0);
        rd("abort_mem", 32'hC, 2'b10, 32'hAAAA0000);

        en = 1'b1; wen = 1'b0; addr = 32'h0; size = 2'b10;
        wait_done(n);
        chk("b2b_first", n, 3);
        wait_done(n);
        chk("b2b_gap", n, 4);
        en = 1'b0;
        chk("b2b_dout", dout, 32'hDEADBEEF);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
